led_step_sequencer: RTL and testbench
=====================================

# led_step_sequencer

Consumes the slow divided clock from the clock-divider stage and turns it into visible LED activity. The divided clock is synchronised into the `clk` domain and edge-detected into a one-cycle `tick`. A prescaled `tick` stream advances a mode-selectable pattern state machine (rotate left, rotate right, binary count, optional bounce). `led` drives the board LEDs directly.

## Interface
- `WIDTH`, default 8: number of LED outputs; minimum 2.
- `PRESCALE`, default 1: `tick`s per pattern step; range 1..2**PRE_W-1.
- `PRE_W`, default 4: prescale counter width.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `div_clk`, in, 1: divided clock from the upstream divider; asynchronous to `clk`, high and low phases each at least 3 `clk` periods.
- `run`, in, 1: 1 means sequence; 0 means freeze.
- `mode`, in, 2: 00 rotate-left, 01 rotate-right, 10 count-up, 11 bounce.
- `led`, out, WIDTH: current pattern, active-high, registered.
- `tick`, out, 1: one-cycle pulse per synchronised `div_clk` rising edge, registered.
- `wrap`, out, 1: one-cycle pulse when a step returns the pattern to its seed, registered.

## Operation
- **Synchroniser:** `s1` and `s2` are flops; `s3` delays `s2`. `tick` is registered from `s2 & ~s3`.
- **Prescaler:** counts `tick`s. A step occurs on the edge where `tick`=1 and `pre_cnt`==PRESCALE-1, and `pre_cnt` then clears.
- **`mode` sampling:** `mode` is registered into `mode_q`.
- **FSM states:** S_IDLE, S_LEFT, S_RIGHT, S_COUNT, S_BNC_L, S_BNC_R.
- **Seeds:** S_LEFT 0x..01; S_RIGHT 0x80..0 (MSB only); S_COUNT 0; bounce 0x..01 entering S_BNC_L.
- **S_IDLE, `run`=1:** next edge enters the state for `mode_q`, loads the seed, clears `pre_cnt`. `wrap` does not pulse.
- **Any run state, `run`=0:** next edge enters S_IDLE. `led` holds its value; `pre_cnt` holds.
- **`mode_q` change while running:** next edge enters the new mode's state, loads the seed, clears `pre_cnt`. This takes priority over a coincident step.
- **Per-step behaviour:**
  - S_LEFT: rotate left; MSB wraps to LSB and pulses `wrap`.
  - S_RIGHT: rotate right; LSB wraps to MSB and pulses `wrap`.
  - S_COUNT: `led`+1 modulo 2**WIDTH; the 2**WIDTH-1 to 0 transition pulses `wrap`.
  - S_BNC_L: shift left; on reaching the MSB, go to S_BNC_R.
  - S_BNC_R: shift right; on reaching the LSB, go to S_BNC_L and pulse `wrap`. The end LEDs are shown for one step each, not two.
- **`tick` in S_IDLE:** still generated; no steps occur.

## Timing
- **Reset values (asynchronous, all):** `led`=0, `tick`=0, `wrap`=0, state S_IDLE, `pre_cnt`=0, `mode_q`=00, `s1`/`s2`/`s3`=0.
- **Reset mid-sequence:** immediate clear. After release, S_IDLE until `run` is seen high.
- **`tick` latency:** `div_clk` first sampled high at edge k; `tick` is high for the single cycle after edge k+2.
- **Step latency:** `led` and `wrap` update at the edge ending the qualifying `tick` cycle, one cycle after `tick` rises. `wrap` is high for exactly that following cycle.
- **`mode` latency:** a change seen at edge m puts the seed on `led` after edge m+1.
- **Minimum `led` hold:** one `div_clk` period times PRESCALE.

## Configuration
- **Macro `LED_SEQ_BOUNCE_EN`, defined:** mode 11 runs S_BNC_L/S_BNC_R as above.
- **Not defined:** the bounce states are not built, and mode 11 decodes to S_LEFT (identical behaviour to mode 00).

## Test plan
1. **Tick and latency:** reset, `run`=1, `mode`=00, PRESCALE=1, `div_clk` period 10 `clk` -> `led` 0x01 after start, then 0x02, 0x04, …, 0x80, 0x01. Each `tick` is exactly 1 cycle; `led` changes 1 cycle after `tick`; `wrap` pulses on 0x80 to 0x01 only.
2. **Prescale:** PRESCALE=3, `mode`=01 -> `led` 0x80, 0x40, 0x20, one step per 3 `tick`s; the `tick` count between changes is exactly 3.
3. **Count wrap:** WIDTH=4, `mode`=10 -> 0..15 then 0. `wrap` is high exactly once, coincident with the 15 to 0 transition.
4. **Bounce (macro defined):** `mode`=11 -> 0x01,0x02,…,0x80,0x40,…,0x01, with `wrap` at the return to 0x01. With the macro undefined, the same stimulus matches scenario 1.
5. **Mode change and freeze:** at `led`=0x08 in mode 00, set `mode`=01 -> seed 0x80 two edges later, `pre_cnt` cleared. Then `run`=0 -> `led` frozen at its current value over 5 `tick`s; `run`=1 -> reloads 0x80.
6. **Reset mid-operation:** assert `rst_n`=0 at `led`=0x10 with `tick` high -> `led`, `tick`, `wrap` read 0 in the same cycle. After release with `run`=1, the sequence restarts from seed 0x01.

Source files
------------

// File: rtl/led_step_sequencer.sv
// led_step_sequencer: synchronises div_clk into a one-cycle tick and steps a mode-selected LED pattern.
// Optional bounce pattern (mode 11) is built only when LED_SEQ_BOUNCE_EN is defined.
module led_step_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned PRE_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic             run,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] SEED_LSB = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_COUNT
`ifdef LED_SEQ_BOUNCE_EN
        ,
        S_BNC_L,
        S_BNC_R
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick_q, tick_d;
    logic             s1_q, s2_q, s3_q;
    logic [1:0]       mode_q;

    state_t           target_state;
    logic [WIDTH-1:0] seed_val;
    logic             mode_match;

    // Decode the registered mode into its run state and seed pattern.
    always_comb begin
        target_state = S_LEFT;
        case (mode_q)
            2'b01:   target_state = S_RIGHT;
            2'b10:   target_state = S_COUNT;
`ifdef LED_SEQ_BOUNCE_EN
            2'b11:   target_state = S_BNC_L;
`endif
            default: target_state = S_LEFT;
        endcase

        case (target_state)
            S_RIGHT: seed_val = SEED_MSB;
            S_COUNT: seed_val = '0;
            default: seed_val = SEED_LSB;
        endcase

        mode_match = (state_q == target_state);
`ifdef LED_SEQ_BOUNCE_EN
        if (target_state == S_BNC_L && state_q == S_BNC_R) begin
            mode_match = 1'b1;
        end
`endif
    end

    // Next-state, pattern and prescaler logic.
    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        pre_cnt_d = pre_cnt_q;
        wrap_d    = 1'b0;
        tick_d    = s2_q & ~s3_q;

        if (state_q == S_IDLE) begin
            if (run) begin
                state_d   = target_state;
                led_d     = seed_val;
                pre_cnt_d = '0;
            end
        end else if (!run) begin
            state_d = S_IDLE;
        end else if (!mode_match) begin
            // A mode change reseeds and wins over any coincident step.
            state_d   = target_state;
            led_d     = seed_val;
            pre_cnt_d = '0;
        end else if (tick_q) begin
            if (pre_cnt_q == PRE_LAST) begin
                pre_cnt_d = '0;
                case (state_q)
                    S_LEFT: begin
                        led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                        wrap_d = led_q[WIDTH-1];
                    end
                    S_RIGHT: begin
                        led_d  = {led_q[0], led_q[WIDTH-1:1]};
                        wrap_d = led_q[0];
                    end
                    S_COUNT: begin
                        led_d  = led_q + WIDTH'(1);
                        wrap_d = &led_q;
                    end
`ifdef LED_SEQ_BOUNCE_EN
                    S_BNC_L: begin
                        led_d = led_q << 1;
                        if (led_q[WIDTH-2]) begin
                            state_d = S_BNC_R;
                        end
                    end
                    S_BNC_R: begin
                        led_d = led_q >> 1;
                        if (led_q[1]) begin
                            state_d = S_BNC_L;
                            wrap_d  = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            led_q     <= '0;
            pre_cnt_q <= '0;
            wrap_q    <= 1'b0;
            tick_q    <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            mode_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            pre_cnt_q <= pre_cnt_d;
            wrap_q    <= wrap_d;
            tick_q    <= tick_d;
            s1_q      <= div_clk;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            mode_q    <= mode;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Scoreboard bench for led_step_sequencer: three instances (8/1, 8/3, 4/1) share clk, div_clk and mode.
// Expected LED events are queued by the stimulus and popped by per-instance monitors.
module tb_led_step_sequencer;

    typedef struct packed {
        logic [7:0] led;
        logic       wrap;
        logic       step;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       div_clk = 1'b0;
    logic       run_a   = 1'b0;
    logic       run_p   = 1'b0;
    logic       run_c   = 1'b0;
    logic [1:0] mode    = 2'b00;

    logic [7:0] led_a, led_p;
    logic [3:0] led_c;
    logic       tick_a, tick_p, tick_c;
    logic       wrap_a, wrap_p, wrap_c;

    int n_cmp = 0;
    int n_err = 0;

    exp_t qa[$];
    exp_t qp[$];
    exp_t qc[$];

    led_step_sequencer #(.WIDTH(8), .PRESCALE(1), .PRE_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .run(run_a), .mode(mode),
        .led(led_a), .tick(tick_a), .wrap(wrap_a)
    );
    led_step_sequencer #(.WIDTH(8), .PRESCALE(3), .PRE_W(4)) dut_p (
        .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .run(run_p), .mode(mode),
        .led(led_p), .tick(tick_p), .wrap(wrap_p)
    );
    led_step_sequencer #(.WIDTH(4), .PRESCALE(1), .PRE_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .run(run_c), .mode(mode),
        .led(led_c), .tick(tick_c), .wrap(wrap_c)
    );

    always #5 clk = ~clk;

    // div_clk period is 10 clk periods, edges kept 3 ns clear of clk rising edges.
    initial begin
        #2;
        forever #50 div_clk = ~div_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int which, input logic [7:0] l, input logic w, input logic s);
        exp_t e;
        e.led  = l;
        e.wrap = w;
        e.step = s;
        if (which == 0) qa.push_back(e);
        else if (which == 1) qp.push_back(e);
        else qc.push_back(e);
    endtask

    function automatic int qsize(input int which);
        if (which == 0) return qa.size();
        if (which == 1) return qp.size();
        return qc.size();
    endfunction

    task automatic wait_empty(input int which, input string name);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            if (qsize(which) == 0) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout with %0d expected events pending", name, qsize(which));
        if (which == 0) qa.delete();
        else if (which == 1) qp.delete();
        else qc.delete();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    // Expected tick: div_clk sampled high at edge k and low at k-1 gives tick after edge k+2.
    logic [3:0] samp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) samp <= '0;
        else        samp <= {samp[2:0], div_clk};
    end

    always @(negedge clk) begin
        logic et;
        et = samp[2] & ~samp[3];
        if (rst_n) begin
            if (et || tick_a) check("tick_a", 32'(tick_a), 32'(et));
            if (et || tick_c) check("tick_c", 32'(tick_c), 32'(et));
        end
    end

    logic [7:0] prev_a = '0;
    logic       tprev_a = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_a  <= '0;
            tprev_a <= 1'b0;
        end else begin
            if (led_a !== prev_a || wrap_a) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL a_unexpected: led=0x%0h wrap=%0b at %0t", led_a, wrap_a, $time);
                end else begin
                    e = qa.pop_front();
                    check("a_led", 32'(led_a), 32'(e.led));
                    check("a_wrap", 32'(wrap_a), 32'(e.wrap));
                    if (e.step) check("a_tick_before_step", 32'(tprev_a), 1);
                end
            end
            prev_a  <= led_a;
            tprev_a <= tick_a;
        end
    end

    logic [7:0] prev_p = '0;
    int         cnt_p  = 0;
    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (!rst_n) begin
            prev_p <= '0;
            cnt_p  <= 0;
        end else begin
            c = cnt_p;
            if (led_p !== prev_p || wrap_p) begin
                if (qp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL p_unexpected: led=0x%0h wrap=%0b at %0t", led_p, wrap_p, $time);
                end else begin
                    e = qp.pop_front();
                    check("p_led", 32'(led_p), 32'(e.led));
                    check("p_wrap", 32'(wrap_p), 32'(e.wrap));
                    if (e.step) check("p_ticks_per_step", 32'(c), 3);
                end
                c = 0;
            end
            if (tick_p) c++;
            cnt_p  <= c;
            prev_p <= led_p;
        end
    end

    logic [3:0] prev_c  = '0;
    logic       tprev_c = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_c  <= '0;
            tprev_c <= 1'b0;
        end else begin
            if (led_c !== prev_c || wrap_c) begin
                if (qc.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL c_unexpected: led=0x%0h wrap=%0b at %0t", led_c, wrap_c, $time);
                end else begin
                    e = qc.pop_front();
                    check("c_led", 32'({4'b0, led_c}), 32'(e.led));
                    check("c_wrap", 32'(wrap_c), 32'(e.wrap));
                    if (e.step) check("c_tick_before_step", 32'(tprev_c), 1);
                end
            end
            prev_c  <= led_c;
            tprev_c <= tick_c;
        end
    end

    initial begin
        int  nt;
        logic found;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        #1;
        check("rst_led_a", 32'(led_a), 0);
        check("rst_tick_a", 32'(tick_a), 0);
        check("rst_wrap_a", 32'(wrap_a), 0);
        check("rst_led_p", 32'(led_p), 0);
        check("rst_led_c", 32'({4'b0, led_c}), 0);
        rst_n = 1'b1;

        // Rotate left, prescale 1: full lap plus one step.
        mode = 2'b00;
        push(0, 8'h01, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) push(0, 8'(1 << i), 1'b0, 1'b1);
        push(0, 8'h01, 1'b1, 1'b1);
        push(0, 8'h02, 1'b0, 1'b1);
        run_a = 1'b1;
        wait_empty(0, "s1_rotate_left");
        run_a = 1'b0;

        // Rotate right, prescale 3.
        mode = 2'b01;
        settle();
        push(1, 8'h80, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) push(1, 8'(1 << i), 1'b0, 1'b1);
        push(1, 8'h80, 1'b1, 1'b1);
        run_p = 1'b1;
        wait_empty(1, "s2_prescale");
        run_p = 1'b0;

        // 4-bit count; seed 0 equals the reset value so no seed event is seen.
        mode = 2'b10;
        settle();
        for (int i = 1; i < 16; i++) push(2, 8'(i), 1'b0, 1'b1);
        push(2, 8'h00, 1'b1, 1'b1);
        run_c = 1'b1;
        wait_empty(2, "s3_count");
        run_c = 1'b0;

        // Mode 11: bounce when built, otherwise identical to rotate left.
        mode = 2'b11;
        settle();
        push(0, 8'h01, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) push(0, 8'(1 << i), 1'b0, 1'b1);
`ifdef LED_SEQ_BOUNCE_EN
        for (int i = 6; i >= 1; i--) push(0, 8'(1 << i), 1'b0, 1'b1);
        push(0, 8'h01, 1'b1, 1'b1);
`else
        push(0, 8'h01, 1'b1, 1'b1);
`endif
        push(0, 8'h02, 1'b0, 1'b1);
        run_a = 1'b1;
        wait_empty(0, "s4_mode11");
        run_a = 1'b0;

        // Mode change at 0x08: seed 0x80 two edges later.
        mode = 2'b00;
        settle();
        push(0, 8'h01, 1'b0, 1'b0);
        push(0, 8'h02, 1'b0, 1'b1);
        push(0, 8'h04, 1'b0, 1'b1);
        push(0, 8'h08, 1'b0, 1'b1);
        run_a = 1'b1;
        wait_empty(0, "s5_to_08");
        push(0, 8'h80, 1'b0, 1'b0);
        mode = 2'b01;
        @(posedge clk);
        #1;
        check("mode_lat_edge1", 32'(led_a), 32'h08);
        @(posedge clk);
        #1;
        check("mode_lat_edge2", 32'(led_a), 32'h80);
        push(0, 8'h40, 1'b0, 1'b1);
        push(0, 8'h20, 1'b0, 1'b1);
        wait_empty(0, "s5_right");
        run_a = 1'b0;

        // Freeze over 5 ticks, then resume from the seed.
        nt = 0;
        for (int i = 0; i < 200 && nt < 5; i++) begin
            @(negedge clk);
            if (tick_a) nt++;
        end
        #1;
        check("freeze_ticks", 32'(nt), 5);
        check("freeze_hold", 32'(led_a), 32'h20);
        push(0, 8'h80, 1'b0, 1'b0);
        push(0, 8'h40, 1'b0, 1'b1);
        run_a = 1'b1;
        wait_empty(0, "s5_resume");
        run_a = 1'b0;

        // Reset at led 0x10 while tick is high.
        mode = 2'b00;
        settle();
        push(0, 8'h01, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) push(0, 8'(1 << i), 1'b0, 1'b1);
        run_a = 1'b1;
        wait_empty(0, "s6_to_10");
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (tick_a) found = 1'b1;
        end
        check("s6_tick_seen", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_led", 32'(led_a), 0);
        check("s6_rst_tick", 32'(tick_a), 0);
        check("s6_rst_wrap", 32'(wrap_a), 0);
        push(0, 8'h01, 1'b0, 1'b0);
        push(0, 8'h02, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_empty(0, "s6_restart");
        run_a = 1'b0;

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
